// File: rtl/wb_ic_pkg.sv
// Shared types and constants for the Wishbone memory interconnect.
// The optional slave-ack timeout is enabled with WB_MEM_IC_TIMEOUT_EN.
package wb_ic_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFwd     = 2'd1,
    StAck     = 2'd2,
    StRelease = 2'd3
  } wb_ic_state_e;

  localparam int unsigned ErrData              = 0;
  localparam int unsigned DefaultTimeoutCycles = 255;

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational base/size window decoder: returns hit, one-hot select, index and offset.
// Part of wishbone_mem_interconnect_n (timeout option WB_MEM_IC_TIMEOUT_EN lives in the top).
module wb_addr_decode
  import wb_ic_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_SIZE = '0,
  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_W-1:0]     adr,
  output logic                  hit,
  output logic [NUM_SLAVES-1:0] onehot,
  output logic [IDX_W-1:0]      idx,
  output logic [ADDR_W-1:0]     offset
);

  // Limit is computed one bit wider so a window ending at 2^ADDR_W does not wrap.
  function automatic logic in_window(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] size);
    logic [ADDR_W:0] lim;
    lim = {1'b0, base} + {1'b0, size};
    return (size != '0) && (a >= base) && ({1'b0, a} < lim);
  endfunction

  always_comb begin
    hit    = 1'b0;
    onehot = '0;
    idx    = '0;
    offset = '0;
    // Scan downward so the lowest matching index is applied last and wins.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (in_window(adr, SLAVE_BASE[i*ADDR_W +: ADDR_W], SLAVE_SIZE[i*ADDR_W +: ADDR_W])) begin
        hit       = 1'b1;
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
        offset    = adr - SLAVE_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/wishbone_mem_interconnect_n.sv
// One-master, N-slave Wishbone memory interconnect with registered request/ack and
// self-answered unmapped accesses. Define WB_MEM_IC_TIMEOUT_EN for the slave-ack timeout.
module wishbone_mem_interconnect_n
  import wb_ic_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_SIZE = '0,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles,
  localparam int unsigned SEL_W = DATA_W / 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_m_we,
  input  logic                         i_m_stb,
  input  logic                         i_m_cyc,
  input  logic [SEL_W-1:0]             i_m_sel,
  input  logic [ADDR_W-1:0]            i_m_adr,
  input  logic [DATA_W-1:0]            i_m_dat,
  output logic [DATA_W-1:0]            o_m_dat,
  output logic                         o_m_ack,
  output logic                         o_m_err,
  output logic                         o_m_int,
  output logic [NUM_SLAVES-1:0]        o_s_we,
  output logic [NUM_SLAVES-1:0]        o_s_stb,
  output logic [NUM_SLAVES-1:0]        o_s_cyc,
  output logic [NUM_SLAVES*SEL_W-1:0]  o_s_sel,
  output logic [NUM_SLAVES*ADDR_W-1:0] o_s_adr,
  output logic [NUM_SLAVES*DATA_W-1:0] o_s_dat,
  input  logic [NUM_SLAVES*DATA_W-1:0] i_s_dat,
  input  logic [NUM_SLAVES-1:0]        i_s_ack,
  input  logic [NUM_SLAVES-1:0]        i_s_int
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic                  dec_hit;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic [IDX_W-1:0]      dec_idx;
  logic [ADDR_W-1:0]     dec_offset;

  wb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_SIZE (SLAVE_SIZE)
  ) u_decode (
    .adr    (i_m_adr),
    .hit    (dec_hit),
    .onehot (dec_onehot),
    .idx    (dec_idx),
    .offset (dec_offset)
  );

  wb_ic_state_e          state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_SLAVES-1:0] act_q;
  logic                  we_q;
  logic [SEL_W-1:0]      sel_q;
  logic [ADDR_W-1:0]     adr_q;
  logic [DATA_W-1:0]     wdat_q;
  logic [DATA_W-1:0]     mdat_q;
  logic                  ack_q;
  logic                  err_q;
  logic                  int_q;
  logic [DATA_W-1:0]     s_rdat [NUM_SLAVES];

`ifdef WB_MEM_IC_TIMEOUT_EN
  logic [15:0] tmo_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      act_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      mdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef WB_MEM_IC_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_m_cyc && i_m_stb) begin
            if (dec_hit) begin
              idx_q   <= dec_idx;
              act_q   <= dec_onehot;
              we_q    <= i_m_we;
              sel_q   <= i_m_sel;
              adr_q   <= dec_offset;
              wdat_q  <= i_m_dat;
              state_q <= StFwd;
`ifdef WB_MEM_IC_TIMEOUT_EN
              tmo_q   <= '0;
`endif
            end else begin
              mdat_q  <= DATA_W'(ErrData);
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              state_q <= StAck;
            end
          end
        end
        StFwd: begin
          sel_q  <= i_m_sel;
          wdat_q <= i_m_dat;
          if (!i_m_cyc) begin
            // Master abort: release the slave without answering.
            act_q   <= '0;
            we_q    <= 1'b0;
            state_q <= StIdle;
          end else if (i_s_ack[idx_q]) begin
            mdat_q  <= s_rdat[idx_q];
            act_q   <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= StAck;
          end
`ifdef WB_MEM_IC_TIMEOUT_EN
          else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
            mdat_q  <= DATA_W'(ErrData);
            act_q   <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            state_q <= StAck;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
`endif
        end
        StAck:     state_q <= StRelease;
        StRelease: if (!i_m_stb) state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) int_q <= 1'b0;
    else     int_q <= |i_s_int;
  end

  // Only the selected slave sees a non-zero request; the rest are held quiet.
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave
    assign o_s_stb[g]                   = act_q[g];
    assign o_s_cyc[g]                   = act_q[g];
    assign o_s_we[g]                    = act_q[g] & we_q;
    assign o_s_sel[g*SEL_W +: SEL_W]    = act_q[g] ? sel_q  : '0;
    assign o_s_adr[g*ADDR_W +: ADDR_W]  = act_q[g] ? adr_q  : '0;
    assign o_s_dat[g*DATA_W +: DATA_W]  = act_q[g] ? wdat_q : '0;
    assign s_rdat[g]                    = i_s_dat[g*DATA_W +: DATA_W];
  end

  assign o_m_dat = mdat_q;
  assign o_m_ack = ack_q;
  assign o_m_err = err_q;
  assign o_m_int = int_q;

endmodule

// File: tb/tb_wishbone_mem_interconnect_n.sv
// Scoreboard bench for wishbone_mem_interconnect_n; checks timeout when
// WB_MEM_IC_TIMEOUT_EN is defined, otherwise checks that the ack never arrives.
module tb_wishbone_mem_interconnect_n;

  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_we, m_stb, m_cyc;
  logic [3:0]   m_sel;
  logic [31:0]  m_adr, m_dat;
  logic [31:0]  mo_dat;
  logic         mo_ack, mo_err, mo_int;
  logic [3:0]   s_we, s_stb, s_cyc;
  logic [15:0]  s_sel;
  logic [127:0] s_adr, s_dat_o, s_dat_i;
  logic [3:0]   s_ack, s_int;

  logic [31:0] base  [4] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_1800, 32'hFFFF_F000};
  logic [31:0] rdata [4] = '{32'h0BAD_F00D, 32'hCAFE_F00D, 32'h5555_AAAA, 32'hDEAD_BEEF};
  int          slv_wait [4];
  bit          slv_mute [4];
  int          slv_cnt  [4];

  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // S1 and S2 overlap on 0x1800-0x1FFF; S3 ends exactly at 2^32.
  wishbone_mem_interconnect_n #(
    .NUM_SLAVES     (4),
    .ADDR_W         (32),
    .DATA_W         (32),
    .SLAVE_BASE     ({32'hFFFF_F000, 32'h0000_1800, 32'h0000_1000, 32'h0000_0000}),
    .SLAVE_SIZE     ({32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000}),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_m_we  (m_we),
    .i_m_stb (m_stb),
    .i_m_cyc (m_cyc),
    .i_m_sel (m_sel),
    .i_m_adr (m_adr),
    .i_m_dat (m_dat),
    .o_m_dat (mo_dat),
    .o_m_ack (mo_ack),
    .o_m_err (mo_err),
    .o_m_int (mo_int),
    .o_s_we  (s_we),
    .o_s_stb (s_stb),
    .o_s_cyc (s_cyc),
    .o_s_sel (s_sel),
    .o_s_adr (s_adr),
    .o_s_dat (s_dat_o),
    .i_s_dat (s_dat_i),
    .i_s_ack (s_ack),
    .i_s_int (s_int)
  );

  always #5 clk = ~clk;

  assign s_dat_i = {rdata[3], rdata[2], rdata[1], rdata[0]};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slave model: ack for one cycle once a strobe has been seen for slv_wait samples.
  always begin
    step();
    for (int i = 0; i < 4; i++) begin
      if (s_stb[i] && s_cyc[i]) begin
        if (!slv_mute[i] && slv_cnt[i] == slv_wait[i] && !s_ack[i]) begin
          s_ack[i] = 1'b1;
        end else begin
          s_ack[i] = 1'b0;
          slv_cnt[i]++;
        end
      end else begin
        s_ack[i]   = 1'b0;
        slv_cnt[i] = 0;
      end
    end
  end

  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                     input logic [3:0] sel, input int slv, input bit exp_err,
                     input int lat, input bit hold);
    exp_t e;
    exp_t g;
    int   n;
    bit   got;
    e.err = exp_err;
    e.dat = exp_err ? 32'h0 : rdata[slv];
    e.lat = lat;
    sb.push_back(e);
    m_we = we; m_adr = adr; m_dat = wdat; m_sel = sel; m_cyc = 1'b1; m_stb = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < 60) begin
      step();
      n++;
      if (n == 1) begin
        if (slv >= 0) begin
          check("stb_onehot", {28'h0, s_stb}, 32'(1 << slv));
          check("cyc_onehot", {28'h0, s_cyc}, 32'(1 << slv));
          check("we_slave",   {28'h0, s_we},  we ? 32'(1 << slv) : 32'h0);
          check("adr_offset", s_adr[slv*32 +: 32], adr - base[slv]);
          check("sel_slave",  {28'h0, s_sel[slv*4 +: 4]}, {28'h0, sel});
          check("dat_slave",  s_dat_o[slv*32 +: 32], wdat);
        end else begin
          check("miss_no_stb", {28'h0, s_stb}, 32'h0);
        end
      end
      if (mo_ack) begin
        got = 1;
        if (sb.size() == 0) begin
          check("sb_empty", 32'h1, 32'h0);
        end else begin
          g = sb.pop_front();
          check("m_dat", mo_dat, g.dat);
          check("m_err", {31'h0, mo_err}, {31'h0, g.err});
          check("latency", n, g.lat);
          check("stb_dropped", {28'h0, s_stb}, 32'h0);
        end
      end
    end
    if (!got) begin
      check("ack_seen", 32'h0, 32'h1);
      void'(sb.pop_front());
    end
    step();
    check("ack_single", {31'h0, mo_ack}, 32'h0);
    if (!hold) begin
      m_cyc = 1'b0;
      m_stb = 1'b0;
      step();
    end
  endtask

  initial begin
    bit any_ack;
    rst = 1'b1;
    m_we = 0; m_stb = 0; m_cyc = 0; m_sel = '0; m_adr = '0; m_dat = '0;
    s_ack = '0; s_int = '0;
    for (int i = 0; i < 4; i++) begin
      slv_wait[i] = 0; slv_mute[i] = 0; slv_cnt[i] = 0;
    end
    repeat (3) step();
    check("rst_ack", {31'h0, mo_ack}, 32'h0);
    check("rst_err", {31'h0, mo_err}, 32'h0);
    check("rst_dat", mo_dat, 32'h0);
    check("rst_stb", {28'h0, s_stb}, 32'h0);
    check("rst_int", {31'h0, mo_int}, 32'h0);
    rst = 1'b0;
    step();

    slv_wait[1] = 2;
    txn(1'b0, 32'h0000_1004, 32'h0, 4'hF, 1, 1'b0, 4, 1'b0);
    slv_wait[0] = 1;
    txn(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011, 0, 1'b0, 3, 1'b0);
    txn(1'b0, 32'h8000_0000, 32'h0, 4'hF, -1, 1'b1, 1, 1'b0);
    slv_wait[0] = 0;
    txn(1'b0, 32'h0000_0FFC, 32'h0, 4'hF, 0, 1'b0, 2, 1'b0);
    slv_wait[1] = 0;
    txn(1'b0, 32'h0000_1800, 32'h0, 4'hF, 1, 1'b0, 2, 1'b0);
    txn(1'b1, 32'h0000_2000, 32'hA5A5_0F0F, 4'b1100, 2, 1'b0, 2, 1'b0);
    txn(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 3, 1'b0, 2, 1'b0);
    txn(1'b0, 32'h0000_2800, 32'h0, 4'hF, -1, 1'b1, 1, 1'b0);

    // Stb held after ack: nothing new until the master drops it.
    txn(1'b0, 32'h0000_2004, 32'h0, 4'hF, 2, 1'b0, 2, 1'b1);
    any_ack = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      any_ack |= mo_ack | (s_stb != 4'h0);
    end
    check("hold_no_new", {31'h0, any_ack}, 32'h0);
    m_stb = 1'b0; m_cyc = 1'b0;
    step();
    txn(1'b0, 32'h0000_0004, 32'h0, 4'hF, 0, 1'b0, 2, 1'b0);

    // Master abort during FWD.
    slv_wait[1] = 10;
    m_we = 0; m_adr = 32'h0000_1008; m_sel = 4'hF; m_cyc = 1; m_stb = 1;
    repeat (3) step();
    check("abort_pre_stb", {28'h0, s_stb}, 32'h2);
    m_cyc = 0; m_stb = 0;
    step();
    check("abort_stb", {28'h0, s_stb}, 32'h0);
    any_ack = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      any_ack |= mo_ack;
    end
    check("abort_no_ack", {31'h0, any_ack}, 32'h0);

    // Slave that never acks.
    slv_mute[0] = 1;
`ifdef WB_MEM_IC_TIMEOUT_EN
    txn(1'b0, 32'h0000_0020, 32'h0, 4'hF, 0, 1'b1, TMO + 1, 1'b0);
`else
    m_adr = 32'h0000_0020; m_cyc = 1; m_stb = 1;
    any_ack = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      any_ack |= mo_ack;
    end
    check("noack_no_ack", {31'h0, any_ack}, 32'h0);
    check("noack_stb", {28'h0, s_stb}, 32'h1);
    m_cyc = 0; m_stb = 0;
    step();
    check("noack_abort_stb", {28'h0, s_stb}, 32'h0);
`endif
    slv_mute[0] = 0;

    // Reset in the middle of FWD.
    m_adr = 32'h0000_1010; m_cyc = 1; m_stb = 1;
    repeat (2) step();
    check("midrst_pre_stb", {28'h0, s_stb}, 32'h2);
    rst = 1; m_cyc = 0; m_stb = 0;
    step();
    check("midrst_stb", {28'h0, s_stb}, 32'h0);
    check("midrst_cyc", {28'h0, s_cyc}, 32'h0);
    check("midrst_ack", {31'h0, mo_ack}, 32'h0);
    rst = 0;
    step();
    txn(1'b0, 32'h9000_0000, 32'h0, 4'hF, -1, 1'b1, 1, 1'b0);

    // Interrupt OR with one-cycle latency.
    s_int = 4'b0100;
    check("int_pre", {31'h0, mo_int}, 32'h0);
    step();
    check("int_set", {31'h0, mo_int}, 32'h1);
    s_int = 4'b0000;
    step();
    check("int_clr", {31'h0, mo_int}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
